// File: rtl/urcpu_alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default width,
// opcode encodings, FSM state encoding and the response flag bundle.
package urcpu_alu_pkg;

  localparam int ALU_WIDTH = 20;
  // Shift count register width; b[4:0] can never ask for more than 31.
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SHL = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the
// arbiter. slave = arbiter side, master = requester/consumer side.
interface alu_arbiter_if
  import urcpu_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, on conflict the requester
// that did not win last time gets the grant. Purely combinational.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the valids and the previous winner
  always_comb begin
    grant_o = {valid1_i, valid0_i};
    if (valid0_i && valid1_i) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter. One operation in flight at a time:
// IDLE (grant/accept) -> EXEC (evaluate) -> [SHIFT x n] -> RESP (hold).
// SHL is sequenced one bit per cycle through the same adder used by ADD/SUB.
module alu_arbiter
  import urcpu_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = (WIDTH > 31) ? 5'd31 : CNT_W'(WIDTH);

  arb_state_e state_q, state_d;

  logic [1:0]            req_vld, grant, req_rdy;
  logic [1:0][2:0]       req_op;
  logic [1:0][WIDTH-1:0] req_a, req_b;
  logic                  hs, hs_id;

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rsp_flags_t       flags_q, flags_d;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  rsp_flags_t       alu_flags;
  logic [CNT_W-1:0] shl_cnt;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign req_op  = {bus.req1_op, bus.req0_op};
  assign req_a   = {bus.req1_a, bus.req0_a};
  assign req_b   = {bus.req1_b, bus.req0_b};

  rr_arb2 u_rr (
    .valid0_i     (req_vld[0]),
    .valid1_i     (req_vld[1]),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Readys only offered from IDLE and never while reset is asserted
  assign req_rdy        = (state_q == S_IDLE && !rst) ? grant : 2'b00;
  assign bus.req0_ready = req_rdy[0];
  assign bus.req1_ready = req_rdy[1];
  assign hs             = |(req_vld & req_rdy);
  assign hs_id          = req_rdy[1];

  // Shared adder: operands for ADD/OR-path, inverted b for SUB, acc+acc for SHIFT
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_cin = 1'b0;
    if (state_q == S_SHIFT) begin
      add_x = acc_q;
      add_y = acc_q;
    end else if (op_q == OP_SUB) begin
      add_y   = ~b_q;
      add_cin = 1'b1;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

  // Single-cycle result for EXEC; SHL yields a here and is finished in SHIFT
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_ADD: begin
        alu_res         = add_sum[WIDTH-1:0];
        alu_flags.carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        // a + ~b + 1 carries out exactly when no borrow is needed
        alu_res         = add_sum[WIDTH-1:0];
        alu_flags.carry = ~add_sum[WIDTH];
      end
      OP_SHL:  alu_res = a_q;
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
  end

  // Shifting beyond the word clears it, so the count saturates at WIDTH
  assign shl_cnt = (b_q[4:0] > CNT_MAX) ? CNT_MAX : b_q[4:0];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hs) state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_SHL && shl_cnt != '0) ? S_SHIFT : S_RESP;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture on handshake, evaluate in EXEC, step in SHIFT
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flags_d      = flags_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          op_d         = req_op[hs_id];
          a_d          = req_a[hs_id];
          b_d          = req_b[hs_id];
          id_d         = hs_id;
          last_grant_d = hs_id;
        end
      end
      S_EXEC: begin
        acc_d   = alu_res;
        flags_d = alu_flags;
        if (op_q == OP_SHL) cnt_d = shl_cnt;
      end
      S_SHIFT: begin
        acc_d         = add_sum[WIDTH-1:0];
        flags_d.carry = acc_q[WIDTH-1];
        flags_d.zero  = (add_sum[WIDTH-1:0] == '0);
        cnt_d         = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset leaves requester 0 winning the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      acc_q        <= '0;
      cnt_q        <= '0;
      flags_q      <= '{zero: 1'b1, carry: 1'b0, err: 1'b0};
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = acc_q;
  assign bus.rsp_zero  = flags_q.zero;
  assign bus.rsp_carry = flags_q.carry;
  assign bus.rsp_err   = flags_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors, round-robin conflicts, SHL
// latency, response back-pressure, reset mid-operation, then random traffic
// scored against an arithmetic reference model.
module tb_alu_arbiter;
  import urcpu_alu_pkg::*;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         c;
    logic         e;
    int           lat;
  } exp_t;

  req_t q0[$], q1[$];
  int   ids[$];
  int   tests = 0;
  int   fails = 0;
  bit   m_last;
  logic [W-1:0] r_data;
  logic r_zero, r_carry, r_err;
  int   r_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
  endfunction

  // Reference: what the operation means arithmetically, and how long it takes
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, m, s;
    int     n;
    ua = longint'(a);
    ub = longint'(b);
    m  = longint'(1) << W;
    e.d = '0; e.c = 1'b0; e.e = 1'b0; e.lat = 2;
    case (op)
      3'd0: e.d = W'(ua & ub);
      3'd1: e.d = W'(ua | ub);
      3'd2: e.d = W'(ua ^ ub);
      3'd3: begin s = ua + ub; e.d = W'(s % m); e.c = (s >= m); end
      3'd4: begin s = ua - ub + m; e.d = W'(s % m); e.c = (ua < ub); end
      3'd5: begin
        n = int'(ub % 32);
        if (n > W) n = W;
        e.d   = W'((ua << n) % m);
        e.c   = (n > 0) ? 1'(ua >> (W - n)) : 1'b0;
        e.lat = 2 + n;
      end
      default: e.e = 1'b1;
    endcase
    e.z = (e.d == '0);
    return e;
  endfunction

  task automatic drive(input int k, input logic v, input req_t r);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_op = r.op; bus.req0_a = r.a; bus.req0_b = r.b;
    end else begin
      bus.req1_valid = v; bus.req1_op = r.op; bus.req1_a = r.a; bus.req1_b = r.b;
    end
  endtask

  // Issue everything queued on both requesters, one transaction at a time
  task automatic serve(input int hold);
    req_t r;
    exp_t e;
    int   w, cyc;
    logic v0, v1;
    logic [W-1:0] snap;
    while (q0.size() > 0 || q1.size() > 0) begin
      @(negedge clk);
      v0 = (q0.size() > 0);
      v1 = (q1.size() > 0);
      drive(0, v0, v0 ? q0[0] : rnd_req());
      drive(1, v1, v1 ? q1[0] : rnd_req());
      bus.rsp_ready = (hold == 0);
      if (v0 && v1) w = m_last ? 0 : 1;
      else          w = v0 ? 0 : 1;
      #1;
      check("req0_ready", bus.req0_ready, w == 0);
      check("req1_ready", bus.req1_ready, w == 1);
      @(posedge clk); #1;
      r = (w == 0) ? q0.pop_front() : q1.pop_front();
      m_last = (w == 1);
      e = model(r.op, r.a, r.b);
      // Garbage on both requesters while busy must not be accepted
      drive(0, 1'b1, rnd_req());
      drive(1, 1'b1, rnd_req());
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.rsp_valid && cyc < 40);
      check("latency", cyc, e.lat);
      check("rsp_id", bus.rsp_id, w);
      check("rsp_data", bus.rsp_data, e.d);
      check("rsp_zero", bus.rsp_zero, e.z);
      check("rsp_carry", bus.rsp_carry, e.c);
      check("rsp_err", bus.rsp_err, e.e);
      check("resp_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
      ids.push_back(int'(bus.rsp_id));
      r_data = bus.rsp_data; r_zero = bus.rsp_zero; r_carry = bus.rsp_carry;
      r_err = bus.rsp_err; r_lat = cyc;
      snap = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", bus.rsp_valid, 1'b1);
        check("hold_data", bus.rsp_data, snap);
        check("hold_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, {e.z, e.c, e.e});
        check("hold_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      drive(0, 1'b0, rnd_req());
      drive(1, 1'b0, rnd_req());
      @(negedge clk);
      check("rsp_drop", bus.rsp_valid, 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int exp_ord[4] = '{0, 1, 0, 1};

    // Reset state with both valids high: nothing may be granted
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, rnd_req());
    drive(1, 1'b1, rnd_req());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.rsp_valid, 1'b0);
    check("rst_data", bus.rsp_data, '0);
    check("rst_zero", bus.rsp_zero, 1'b1);
    check("rst_carry", bus.rsp_carry, 1'b0);
    check("rst_err", bus.rsp_err, 1'b0);
    check("rst_id", bus.rsp_id, 1'b0);
    check("rst_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
    rst = 1'b0;
    drive(0, 1'b0, rnd_req());
    drive(1, 1'b0, rnd_req());
    m_last = 1'b1;

    // OR vector
    q0.push_back(mk(3'd1, 20'h00F0F, 20'hF0000));
    serve(0);
    check("or_data", r_data, 20'hF0F0F);
    check("or_zero", r_zero, 1'b0);
    check("or_lat", r_lat, 2);

    // SUB borrow and ADD wrap on requester 1
    q1.push_back(mk(3'd4, 20'h00005, 20'h00007));
    serve(0);
    check("sub_data", r_data, 20'hFFFFE);
    check("sub_carry", r_carry, 1'b1);
    q1.push_back(mk(3'd3, 20'hFFFFF, 20'h00001));
    serve(0);
    check("add_data", r_data, 20'h00000);
    check("add_zero", r_zero, 1'b1);
    check("add_carry", r_carry, 1'b1);

    // Both requesters busy with two ops each: strict alternation from 0
    ids.delete();
    q0.push_back(rnd_req()); q0.push_back(rnd_req());
    q1.push_back(rnd_req()); q1.push_back(rnd_req());
    serve(0);
    check("order_len", ids.size(), 4);
    for (int i = 0; i < 4; i++) check("order", ids[i], exp_ord[i]);

    // SHL latencies: n, zero count, saturated count
    q0.push_back(mk(3'd5, 20'h00003, 20'd4));
    serve(0);
    check("shl4_data", r_data, 20'h00030);
    check("shl4_lat", r_lat, 6);
    q1.push_back(mk(3'd5, 20'h1A2B3, 20'd0));
    serve(0);
    check("shl0_data", r_data, 20'h1A2B3);
    check("shl0_lat", r_lat, 2);
    q0.push_back(mk(3'd5, 20'h00003, 20'd25));
    serve(0);
    check("shl25_data", r_data, 20'h00000);
    check("shl25_lat", r_lat, 22);

    // Illegal opcode under 5 cycles of back-pressure
    q1.push_back(mk(3'd7, 20'h12345, 20'h54321));
    serve(5);
    check("ill_err", r_err, 1'b1);
    check("ill_zero", r_zero, 1'b1);

    // Random traffic, random back-pressure
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel != 1) q0.push_back(rnd_req());
      if (sel != 0) q1.push_back(rnd_req());
      serve($urandom_range(0, 2));
    end

    // Reset during SHIFT discards the operation
    @(negedge clk);
    drive(0, 1'b1, mk(3'd5, W'($urandom), 20'd10));
    drive(1, 1'b0, rnd_req());
    bus.rsp_ready = 1'b1;
    #1;
    check("shl_rst_accept", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b1, rnd_req());
    drive(1, 1'b1, rnd_req());
    repeat (4) @(negedge clk);
    check("shifting_valid", bus.rsp_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_data", bus.rsp_data, '0);
    check("mid_rst_zero", bus.rsp_zero, 1'b1);
    check("mid_rst_carry", bus.rsp_carry, 1'b0);
    check("mid_rst_readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
    rst = 1'b0;
    drive(0, 1'b0, rnd_req());
    drive(1, 1'b0, rnd_req());
    m_last = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("stale_rsp", seen, 0);
    ids.delete();
    q0.push_back(rnd_req());
    q1.push_back(rnd_req());
    serve(0);
    check("post_rst_first", ids[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 20, data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 reqK_valid  input  1  requester K (K=0,1) presents an operation.
REQ-005 reqK_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 reqK_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6-7 illegal.
REQ-007 reqK_a, reqK_b  input  WIDTH  operands; for SHL, b[4:0] is the shift count.
REQ-008 rsp_valid  output  1  response held on the rsp_* outputs.
REQ-009 rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  index of the requester that owns the response.
REQ-011 rsp_data  output  WIDTH  result word.
REQ-012 rsp_zero  output  1  high when rsp_data == 0.
REQ-013 rsp_carry  output  1  ADD carry-out; SUB borrow (a<b unsigned); SHL last bit shifted out; otherwise 0.
REQ-014 rsp_err  output  1  high for an illegal opcode.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, SHIFT and RESP.
REQ-016 reqK_ready SHALL be high only in IDLE, and only for the granted requester; it is combinational from the valids and last_grant.
REQ-017 Grant SHALL be round-robin: a lone valid wins; when both are valid, the requester not in last_grant wins.
REQ-018 A handshake (valid&&ready) SHALL capture op, a, b and id, update last_grant, and move the FSM to EXEC.
REQ-019 In EXEC, for ops 0-4 and 6-7, the arbiter SHALL register the result, zero, carry and err, then go to RESP; rsp_valid rises 2 cycles after the handshake edge.
REQ-020 In EXEC, for SHL: acc<=a, cnt<=min(b[4:0],WIDTH); next state is SHIFT if cnt>0, otherwise RESP with data=a and carry=0.
REQ-021 Each SHIFT cycle SHALL compute acc<=acc+acc (the shared adder path), carry<=acc[WIDTH-1] and cnt<=cnt-1; on reaching cnt==0 the FSM goes to RESP. The response follows the handshake by 2+min(n,WIDTH) cycles.
REQ-022 ADD/SUB SHALL be WIDTH-bit modulo arithmetic; carry comes from the WIDTH+1-bit sum or difference.
REQ-023 An illegal opcode SHALL produce data=0, zero=1, carry=0, err=1.
REQ-024 RESP SHALL hold all rsp_* outputs stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle the response is consumed (minimum issue interval 3 cycles).
REQ-026 rsp_data, rsp_id, rsp_zero, rsp_carry and rsp_err are don't-care while rsp_valid is low, but SHALL be driven from registers (no combinational path from req inputs).
REQ-027 Requester inputs that change while not accepted SHALL have no effect.

Reset
REQ-028 rst SHALL force, in any state: IDLE, rsp_valid=0, rsp_data=0, rsp_zero=1, rsp_carry=0, rsp_err=0, rsp_id=0, cnt=0, last_grant=1 (so requester 0 wins the first conflict).
REQ-029 Reset mid-operation (EXEC, SHIFT or RESP) SHALL discard the operation with no response; both readys are low during the reset cycle.

Structure
REQ-030 The shared package urcpu_alu_pkg SHALL hold the WIDTH default, the opcode encodings and the FSM state encoding.
REQ-031 The round-robin grant SHALL be the sub-module rr_arb2 (inputs: two valids and last_grant; output: one-hot grant).
REQ-032 Combinational ALU logic is internal; RTL target is 150-300 lines.

Verification
REQ-033 Reset, then req0 OR with a=0x00F0F, b=0xF0000, rsp_ready=1 -> rsp_valid at handshake+2, data=0xF0F0F, zero=0, id=0.
REQ-034 Both valid at once, two ops each, rsp_ready=1 -> grant order 0,1,0,1; rsp_id alternates.
REQ-035 req1 SUB a=0x00005, b=0x00007 -> data=0xFFFFE, carry=1; then ADD a=0xFFFFF, b=0x00001 -> data=0, zero=1, carry=1.
REQ-036 SHL a=0x00003, b=4 -> data=0x00030 at handshake+6; SHL b=0 -> data=a at +2; SHL b=25 -> data=0 at +22.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and readys low; op=7 -> err=1, zero=1.
REQ-038 Assert rst during SHIFT -> next cycle IDLE with rsp_valid=0; no stale response after reset.
